zynq_tag_serializer: RTL and testbench

Converts tag commands written by the PS-side shell into the single-wire bsg_tag serial stream. The stream drives the bsg_tag master that distributes the `core_reset` tag lines (PL client at node 0, watchdog client at node 1) defined in `zynq_pkg`. The block sits directly upstream of that master: it accepts one command per valid/ready handshake and serializes it at a divided bit rate with a tag clock.

---
 rtl/zynq_pkg.sv | 31 +++
 rtl/zynq_tag_bit_timer.sv | 43 ++++
 rtl/zynq_tag_serializer.sv | 201 ++++++++++++++++++++
 tb/tb_zynq_tag_serializer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/zynq_pkg.sv
// Shared tag-side definitions: bsg_tag geometry, core_reset node map,
// tag command layout and the tag serializer FSM states.
package zynq_pkg;

  localparam int tag_els_gp               = 16;
  localparam int tag_lg_els_gp            = $clog2(tag_els_gp);
  localparam int tag_max_payload_width_gp = 1;
  localparam int tag_lg_width_gp          = 1;

  // core_reset tag clients
  localparam int core_reset_pl_node_gp = 0;
  localparam int core_reset_wd_node_gp = 1;

  typedef struct packed {
    logic [tag_lg_els_gp-1:0]            nodeid;
    logic                                data_not_reset;
    logic [tag_lg_width_gp-1:0]          len;
    logic [tag_max_payload_width_gp-1:0] payload;
  } zynq_tag_cmd_s;

  typedef enum logic [2:0] {
    TAG_IDLE,
    TAG_START,
    TAG_LEN,
    TAG_DNR,
    TAG_NODE,
    TAG_PAYLOAD,
    TAG_GAP
  } zynq_tag_state_e;

endpackage

// File: rtl/zynq_tag_bit_timer.sv
// Bit-period divider for the tag serializer: produces the tag clock
// (low for the first half of each bit period) and an end-of-bit strobe.
module zynq_tag_bit_timer #(
  parameter int clk_div_p = 4
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic clear_i,
  output logic tag_clk_o,
  output logic bit_done_o
);

  localparam int CW = (clk_div_p > 2) ? $clog2(clk_div_p) : 1;

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_tag_clk;
  logic          w_last;

  assign w_last = (r_cnt == CW'(clk_div_p - 1));

  always_comb begin
    w_cnt_nxt = r_cnt + CW'(1);
    if (clear_i || w_last) begin
      w_cnt_nxt = '0;
    end
  end

  // Tag clock is registered from the next count so it is aligned with r_cnt.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_cnt     <= '0;
      r_tag_clk <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_tag_clk <= (w_cnt_nxt >= CW'(clk_div_p / 2));
    end
  end

  assign tag_clk_o  = r_tag_clk;
  assign bit_done_o = w_last && !clear_i;

endmodule

// File: rtl/zynq_tag_serializer.sv
// Serializes PS-side tag commands into the single-wire bsg_tag stream
// (start, len, data_not_reset, nodeid, payload; all fields LSB first).
module zynq_tag_serializer
  import zynq_pkg::*;
#(
  parameter int els_p               = tag_els_gp,
  parameter int max_payload_width_p = tag_max_payload_width_gp,
  parameter int lg_width_p          = tag_lg_width_gp,
  parameter int clk_div_p           = 4,
  parameter int gap_bits_p          = 2,
  localparam int lg_els_lp          = $clog2(els_p)
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic                           valid_i,
  output logic                           ready_o,
  input  logic [lg_els_lp-1:0]           nodeid_i,
  input  logic                           data_not_reset_i,
  input  logic [lg_width_p-1:0]          len_i,
  input  logic [max_payload_width_p-1:0] payload_i,
  output logic                           tag_data_o,
  output logic                           tag_clk_o,
  output logic                           busy_o
);

  localparam int LW  = lg_width_p;
  localparam int NW  = lg_els_lp;
  localparam int MP  = max_payload_width_p;
  localparam int SW0 = (LW > NW) ? LW : NW;
  localparam int SW  = (SW0 > MP) ? SW0 : MP;
  localparam int IW  = $clog2(SW + gap_bits_p + 1) + 1;

  localparam zynq_tag_state_e POST_PKT = (gap_bits_p > 0) ? TAG_GAP : TAG_IDLE;

  zynq_tag_state_e r_state, w_state_nxt;
  logic [IW-1:0]   r_idx, w_idx_nxt;
  logic [SW-1:0]   r_shift, w_shift_nxt;
  logic            r_data, w_data_nxt;
  logic            r_busy;
  logic            w_load;
  logic [LW-1:0]   w_len_c;
  logic [LW-1:0]   r_len;
  logic            r_dnr;
  logic [NW-1:0]   r_node;
  logic [MP-1:0]   r_payload;
  logic            w_bit_done;
  logic            w_tag_clk;

  zynq_tag_bit_timer #(
    .clk_div_p(clk_div_p)
  ) u_bit_timer (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .clear_i   (r_state == TAG_IDLE),
    .tag_clk_o (w_tag_clk),
    .bit_done_o(w_bit_done)
  );

  always_comb begin
    w_len_c = len_i;
    if (32'(len_i) > 32'(MP)) begin
      w_len_c = LW'(MP);
    end
  end

  // Each field is loaded whole into r_shift on entry; its bit 0 goes straight
  // to the output register and the remainder shifts out on later bit_done.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_data;
    w_load      = 1'b0;

    unique case (r_state)
      TAG_IDLE: begin
        w_data_nxt = 1'b0;
        if (valid_i) begin
          w_load      = 1'b1;
          w_state_nxt = TAG_START;
          w_data_nxt  = 1'b1;
        end
      end

      TAG_START: begin
        if (w_bit_done) begin
          w_state_nxt = TAG_LEN;
          w_idx_nxt   = '0;
          w_data_nxt  = r_len[0];
          w_shift_nxt = SW'(r_len) >> 1;
        end
      end

      TAG_LEN: begin
        if (w_bit_done) begin
          if (r_idx == IW'(LW - 1)) begin
            w_state_nxt = TAG_DNR;
            w_data_nxt  = r_dnr;
          end else begin
            w_idx_nxt   = r_idx + IW'(1);
            w_data_nxt  = r_shift[0];
            w_shift_nxt = r_shift >> 1;
          end
        end
      end

      TAG_DNR: begin
        if (w_bit_done) begin
          w_state_nxt = TAG_NODE;
          w_idx_nxt   = '0;
          w_data_nxt  = r_node[0];
          w_shift_nxt = SW'(r_node) >> 1;
        end
      end

      TAG_NODE: begin
        if (w_bit_done) begin
          if (r_idx == IW'(NW - 1)) begin
            w_idx_nxt = '0;
            if (r_len == '0) begin
              w_state_nxt = POST_PKT;
              w_data_nxt  = 1'b0;
            end else begin
              w_state_nxt = TAG_PAYLOAD;
              w_data_nxt  = r_payload[0];
              w_shift_nxt = SW'(r_payload) >> 1;
            end
          end else begin
            w_idx_nxt   = r_idx + IW'(1);
            w_data_nxt  = r_shift[0];
            w_shift_nxt = r_shift >> 1;
          end
        end
      end

      TAG_PAYLOAD: begin
        if (w_bit_done) begin
          if (r_idx == IW'(r_len) - IW'(1)) begin
            w_state_nxt = POST_PKT;
            w_idx_nxt   = '0;
            w_data_nxt  = 1'b0;
          end else begin
            w_idx_nxt   = r_idx + IW'(1);
            w_data_nxt  = r_shift[0];
            w_shift_nxt = r_shift >> 1;
          end
        end
      end

      TAG_GAP: begin
        w_data_nxt = 1'b0;
        if (w_bit_done) begin
          if (r_idx == IW'(gap_bits_p - 1)) begin
            w_state_nxt = TAG_IDLE;
            w_idx_nxt   = '0;
          end else begin
            w_idx_nxt = r_idx + IW'(1);
          end
        end
      end

      default: begin
        w_state_nxt = TAG_IDLE;
        w_idx_nxt   = '0;
        w_data_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state   <= TAG_IDLE;
      r_idx     <= '0;
      r_shift   <= '0;
      r_data    <= 1'b0;
      r_busy    <= 1'b0;
      r_len     <= '0;
      r_dnr     <= 1'b0;
      r_node    <= '0;
      r_payload <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_data  <= w_data_nxt;
      r_busy  <= (w_state_nxt != TAG_IDLE);
      if (w_load) begin
        r_len     <= w_len_c;
        r_dnr     <= data_not_reset_i;
        r_node    <= nodeid_i;
        r_payload <= payload_i;
      end
    end
  end

  assign ready_o    = (r_state == TAG_IDLE);
  assign tag_data_o = r_data;
  assign tag_clk_o  = w_tag_clk;
  assign busy_o     = r_busy;

endmodule

// File: tb/tb_zynq_tag_serializer.sv
// Self-checking bench for zynq_tag_serializer: a per-cycle waveform model
// built from the packet format is compared against every DUT output.
module tb_zynq_tag_serializer;
  import zynq_pkg::*;

  localparam int DIV  = 4;
  localparam int GAP  = 2;
  localparam int LW   = 1;
  localparam int NW   = 4;
  localparam int MP   = 1;
  localparam int CMDW = $bits(zynq_tag_cmd_s);

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          valid = 1'b0;
  logic          ready;
  logic [NW-1:0] nodeid = '0;
  logic          dnr = 1'b0;
  logic [LW-1:0] len = '0;
  logic [MP-1:0] payload = '0;
  logic          tag_data;
  logic          tag_clk;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  bit m_seq[0:63];
  int m_total = 0;
  int m_p     = 0;
  bit m_idle  = 1'b1;
  bit m_acc   = 1'b0;

  zynq_tag_serializer #(
    .els_p              (16),
    .max_payload_width_p(MP),
    .lg_width_p         (LW),
    .clk_div_p          (DIV),
    .gap_bits_p         (GAP)
  ) dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .valid_i         (valid),
    .ready_o         (ready),
    .nodeid_i        (nodeid),
    .data_not_reset_i(dnr),
    .len_i           (len),
    .payload_i       (payload),
    .tag_data_o      (tag_data),
    .tag_clk_o       (tag_clk),
    .busy_o          (busy)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, act, exp);
    end
  endtask

  task automatic build_packet();
    int k = 0;
    int lc;
    lc = (int'(len) > MP) ? MP : int'(len);
    m_seq[k++] = 1'b1;
    for (int i = 0; i < LW; i++) m_seq[k++] = ((lc >> i) & 1) != 0;
    m_seq[k++] = dnr;
    for (int i = 0; i < NW; i++) m_seq[k++] = nodeid[i];
    for (int i = 0; i < lc; i++) m_seq[k++] = payload[i];
    for (int i = 0; i < GAP; i++) m_seq[k++] = 1'b0;
    m_total = k * DIV;
    m_p     = 0;
  endtask

  task automatic cycle();
    bit ed, ec, eb, er;
    @(posedge aclk);
    if (!aresetn) begin
      m_idle = 1'b1;
    end else if (m_idle) begin
      if (valid) begin
        build_packet();
        m_idle = 1'b0;
        m_acc  = 1'b1;
      end
    end else begin
      m_p++;
      if (m_p == m_total) m_idle = 1'b1;
    end
    @(negedge aclk);
    if (m_idle) begin
      ed = 1'b0; ec = 1'b0; eb = 1'b0; er = 1'b1;
    end else begin
      ed = m_seq[m_p / DIV];
      ec = (m_p % DIV) >= (DIV / 2);
      eb = 1'b1;
      er = 1'b0;
    end
    check("tag_data", 32'(tag_data), 32'(ed));
    check("tag_clk",  32'(tag_clk),  32'(ec));
    check("busy",     32'(busy),     32'(eb));
    check("ready",    32'(ready),    32'(er));
  endtask

  task automatic send(input logic [NW-1:0] n, input logic d,
                      input logic [LW-1:0] l, input logic [MP-1:0] p);
    valid   = 1'b1;
    nodeid  = n;
    dnr     = d;
    len     = l;
    payload = p;
    m_acc   = 1'b0;
    for (int i = 0; i < 200 && !m_acc; i++) cycle();
    if (!m_acc) check("accept_timeout", 0, 1);
  endtask

  task automatic drain();
    valid = 1'b0;
    for (int i = 0; i < 200 && !m_idle; i++) cycle();
    if (!m_idle) check("drain_timeout", 0, 1);
    cycle();
  endtask

  initial begin
    zynq_tag_cmd_s c;
    int gap;

    repeat (3) cycle();
    #1 aresetn = 1'b1;
    repeat (2) cycle();

    // directed packets
    send(4'(core_reset_pl_node_gp), 1'b0, 1'b1, 1'b1);
    drain();
    send(4'(core_reset_wd_node_gp), 1'b1, 1'b1, 1'b0);
    drain();
    send(4'd5, 1'b1, 1'b0, 1'b1);
    drain();

    // valid held high across two commands
    send(4'hA, 1'b1, 1'b1, 1'b1);
    send(4'h3, 1'b0, 1'b0, 1'b0);
    drain();

    // random commands, some back-to-back
    for (int n = 0; n < 40; n++) begin
      c = CMDW'($urandom);
      send(c.nodeid, c.data_not_reset, c.len, c.payload);
      gap = $urandom_range(0, 3);
      if (gap != 0) begin
        valid = 1'b0;
        for (int i = 0; i < 200 && !m_idle; i++) cycle();
        repeat (gap) cycle();
      end
    end
    drain();

    // asynchronous reset in the middle of the nodeid field
    send(4'hF, 1'b1, 1'b1, 1'b1);
    valid = 1'b0;
    for (int i = 0; i < 100 && m_p != 18; i++) cycle();
    check("reach_node_field", m_p, 18);
    check("pre_rst_data", 32'(tag_data), 1);
    #1 aresetn = 1'b0;
    #1;
    m_idle = 1'b1;
    check("rst_data",  32'(tag_data), 0);
    check("rst_clk",   32'(tag_clk),  0);
    check("rst_busy",  32'(busy),     0);
    check("rst_ready", 32'(ready),    1);
    repeat (3) cycle();
    #1 aresetn = 1'b1;
    repeat (2) cycle();
    send(4'h9, 1'b1, 1'b1, 1'b1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
